// File: rtl/otn_pkg.sv
// Shared constants, state encoding and helpers for the OTN frame receiver.
package otn_pkg;

   localparam int unsigned OTN_FRAME_BYTES  = 4164;
   localparam int unsigned OTN_BAUD_DIV     = 20;
   localparam int unsigned OTN_SAMPLE_PHASE = 9;
   localparam int unsigned OTN_ACK_GAP      = 4;
   localparam logic [47:0] OTN_FAS          = 48'hF6F6F6282828;

   typedef enum logic [2:0] {
      ST_HUNT  = 3'd0,
      ST_RECV  = 3'd1,
      ST_CHECK = 3'd2,
      ST_GAP   = 3'd3,
      ST_ACK   = 3'd4
   } rx_state_e;

   // The line carries FAS byte 0 (bits 47:40) first, each byte LSB-first. A
   // right-shifting register fed at bit 47 therefore ends up with byte 0 in
   // bits 7:0; this reorders the bytes into that layout for comparison.
   function automatic logic [47:0] fas_line_order(input logic [47:0] fas);
      logic [47:0] r;
      r = '0;
      for (int i = 0; i < 6; i++) begin
         r[8*i +: 8] = fas[47-8*i -: 8];
      end
      return r;
   endfunction

endpackage

// File: rtl/otn_bit_sampler.sv
// Bit-timing recovery: input synchronizer, transition detect, phase counter
// and mid-bit sample strobe.
module otn_bit_sampler
   import otn_pkg::*;
#(
   parameter int unsigned BAUD_DIV     = OTN_BAUD_DIV,
   parameter int unsigned SAMPLE_PHASE = OTN_SAMPLE_PHASE
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_tick,
   input  logic i_rx,
   output logic o_sample,
   output logic o_bit
);

   localparam int unsigned PW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;

   logic [1:0]    sync_q, sync_d;
   logic          prev_q, prev_d;
   logic [PW-1:0] phase_q, phase_d;
   logic          edge_w;

   // Next-state: shift synchronizer, re-align phase on every line transition.
   always_comb begin
      sync_d  = {sync_q[0], i_rx};
      prev_d  = sync_q[1];
      edge_w  = sync_q[1] ^ prev_q;
      phase_d = phase_q;
      if (edge_w) begin
         phase_d = '0;
      end else if (i_tick) begin
         phase_d = (phase_q == PW'(BAUD_DIV - 1)) ? '0 : phase_q + 1'b1;
      end
   end

   // Register synchronizer, edge history and phase.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q  <= 2'b11;
         prev_q  <= 1'b1;
         phase_q <= '0;
      end else begin
         sync_q  <= sync_d;
         prev_q  <= prev_d;
         phase_q <= phase_d;
      end
   end

   assign o_sample = i_tick && (phase_q == PW'(SAMPLE_PHASE));
   assign o_bit    = sync_q[1];

endmodule

// File: rtl/otn_frame_rx.sv
// OTN frame receiver: FAS hunt, payload delivery with XOR checksum, verdict
// pulse and optional serial ACK return.
module otn_frame_rx
   import otn_pkg::*;
#(
   parameter int unsigned FRAME_BYTES  = OTN_FRAME_BYTES,
   parameter int unsigned BAUD_DIV     = OTN_BAUD_DIV,
   parameter int unsigned SAMPLE_PHASE = OTN_SAMPLE_PHASE,
   parameter int unsigned ACK_GAP      = OTN_ACK_GAP,
   parameter logic [47:0] FAS          = OTN_FAS
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_sclk_en_16_x_baud,
   input  logic       i_otn_rx_data,
   input  logic       i_arq_en,
   output logic [7:0] o_data,
   output logic       o_data_valid,
   output logic       o_data_sof,
   output logic       o_frame_good,
   output logic       o_frame_bad,
   output logic       o_otn_tx_ack,
   output logic [2:0] o_rx_state
);

   localparam int unsigned BW = $clog2(FRAME_BYTES);
   localparam int unsigned DW = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
   localparam int unsigned GW = $clog2(ACK_GAP + 3);
   localparam logic [47:0] FAS_LINE = fas_line_order(FAS);

   rx_state_e     state_q, state_d;
   logic [47:0]   fas_q, fas_d;
   logic [7:0]    byte_q, byte_d;
   logic [2:0]    bit_q, bit_d;
   logic [BW-1:0] cnt_q, cnt_d;
   logic [7:0]    csum_q, csum_d;
   logic [7:0]    data_q, data_d;
   logic          valid_q, valid_d, sof_q, sof_d;
   logic          good_q, good_d, bad_q, bad_d;
   logic          verdict_q, verdict_d, ack_q, ack_d;
   logic [DW-1:0] div_q, div_d;
   logic [GW-1:0] per_q, per_d;

   logic          sample_w, sbit_w, div_wrap_w;
   logic [47:0]   fas_shift_w;
   logic [7:0]    byte_shift_w;

   otn_bit_sampler #(
      .BAUD_DIV     (BAUD_DIV),
      .SAMPLE_PHASE (SAMPLE_PHASE)
   ) u_sampler (
      .i_clk    (i_clk),
      .i_rst_n  (i_rst_n),
      .i_tick   (i_sclk_en_16_x_baud),
      .i_rx     (i_otn_rx_data),
      .o_sample (sample_w),
      .o_bit    (sbit_w)
   );

   // Receiver FSM next-state and registered-output computation.
   always_comb begin
      state_d      = state_q;
      fas_d        = fas_q;
      byte_d       = byte_q;
      bit_d        = bit_q;
      cnt_d        = cnt_q;
      csum_d       = csum_q;
      data_d       = data_q;
      valid_d      = 1'b0;
      sof_d        = 1'b0;
      good_d       = 1'b0;
      bad_d        = 1'b0;
      verdict_d    = verdict_q;
      ack_d        = ack_q;
      div_d        = div_q;
      per_d        = per_q;
      fas_shift_w  = {sbit_w, fas_q[47:1]};
      byte_shift_w = {sbit_w, byte_q[7:1]};
      div_wrap_w   = (div_q == DW'(BAUD_DIV - 1));

      case (state_q)
         ST_HUNT: begin
            if (sample_w) begin
               fas_d = fas_shift_w;
               if (fas_shift_w == FAS_LINE) begin
                  state_d = ST_RECV;
                  cnt_d   = BW'(6);
                  bit_d   = 3'd0;
                  byte_d  = 8'h00;
                  csum_d  = 8'h00;
               end
            end
         end
         ST_RECV: begin
            if (sample_w) begin
               byte_d = byte_shift_w;
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) begin
                  if (cnt_q == BW'(FRAME_BYTES - 1)) begin
                     state_d = ST_CHECK;
                  end else begin
                     data_d  = byte_shift_w;
                     valid_d = 1'b1;
                     sof_d   = (cnt_q == BW'(6));
                     csum_d  = csum_q ^ byte_shift_w;
                     cnt_d   = cnt_q + 1'b1;
                  end
               end
            end
         end
         ST_CHECK: begin
            // byte_q holds the received checksum byte here.
            verdict_d = (byte_q == csum_q);
            good_d    = (byte_q == csum_q);
            bad_d     = (byte_q != csum_q);
            if (i_arq_en) begin
               state_d = ST_GAP;
               div_d   = '0;
               per_d   = '0;
            end else begin
               state_d = ST_HUNT;
               fas_d   = '0;
            end
         end
         ST_GAP: begin
            if (i_sclk_en_16_x_baud) begin
               if (div_wrap_w) begin
                  div_d = '0;
                  if (per_q == GW'(ACK_GAP - 1)) begin
                     state_d = ST_ACK;
                     per_d   = '0;
                     ack_d   = 1'b0;
                  end else begin
                     per_d = per_q + 1'b1;
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         end
         ST_ACK: begin
            // per_q 0: start bit on line, 1: verdict bit, 2: stop bit.
            if (i_sclk_en_16_x_baud) begin
               if (div_wrap_w) begin
                  div_d = '0;
                  per_d = per_q + 1'b1;
                  if (per_q == GW'(0)) begin
                     ack_d = verdict_q;
                  end else if (per_q == GW'(1)) begin
                     ack_d = 1'b0;
                  end else begin
                     ack_d   = 1'b1;
                     per_d   = '0;
                     state_d = ST_HUNT;
                     fas_d   = '0;
                  end
               end else begin
                  div_d = div_q + 1'b1;
               end
            end
         end
         default: begin
            state_d = ST_HUNT;
         end
      endcase
   end

   // Register all FSM state and outputs; reset returns the line to idle high.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= ST_HUNT;
         fas_q     <= '0;
         byte_q    <= '0;
         bit_q     <= '0;
         cnt_q     <= '0;
         csum_q    <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         sof_q     <= 1'b0;
         good_q    <= 1'b0;
         bad_q     <= 1'b0;
         verdict_q <= 1'b0;
         ack_q     <= 1'b1;
         div_q     <= '0;
         per_q     <= '0;
      end else begin
         state_q   <= state_d;
         fas_q     <= fas_d;
         byte_q    <= byte_d;
         bit_q     <= bit_d;
         cnt_q     <= cnt_d;
         csum_q    <= csum_d;
         data_q    <= data_d;
         valid_q   <= valid_d;
         sof_q     <= sof_d;
         good_q    <= good_d;
         bad_q     <= bad_d;
         verdict_q <= verdict_d;
         ack_q     <= ack_d;
         div_q     <= div_d;
         per_q     <= per_d;
      end
   end

   assign o_data       = data_q;
   assign o_data_valid = valid_q;
   assign o_data_sof   = sof_q;
   assign o_frame_good = good_q;
   assign o_frame_bad  = bad_q;
   assign o_otn_tx_ack = ack_q;
   assign o_rx_state   = state_q;

endmodule

// File: tb/tb_otn_frame_rx.sv
// Self-checking bench for otn_frame_rx with a small-frame configuration.
module tb_otn_frame_rx;

   localparam int FB   = 24;
   localparam int BD   = 20;
   localparam int SP   = 9;
   localparam int AG   = 4;
   localparam int NPAY = FB - 7;
   localparam logic [47:0] FAS_TB = 48'hF6F6F6282828;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       tick = 1'b1;
   logic       rx = 1'b1;
   logic       arq_en = 1'b1;
   logic [7:0] o_data;
   logic       o_data_valid, o_data_sof, o_frame_good, o_frame_bad, o_otn_tx_ack;
   logic [2:0] o_rx_state;

   int         checks = 0;
   int         errors = 0;
   bit         gap_mode = 1'b0;
   longint     tick_ctr = 0;

   logic [7:0] frame [FB];
   logic [7:0] got_q [$];
   bit         sof_q [$];
   int         good_cnt = 0, bad_cnt = 0, overlap_cnt = 0;
   longint     good_tick = 0, bad_tick = 0;
   logic       prev_ack = 1'b1;
   longint     ack_edge_t [$];
   logic       ack_edge_v [$];

   otn_frame_rx #(
      .FRAME_BYTES  (FB),
      .BAUD_DIV     (BD),
      .SAMPLE_PHASE (SP),
      .ACK_GAP      (AG),
      .FAS          (FAS_TB)
   ) dut (
      .i_clk               (clk),
      .i_rst_n             (rst_n),
      .i_sclk_en_16_x_baud (tick),
      .i_otn_rx_data       (rx),
      .i_arq_en            (arq_en),
      .o_data              (o_data),
      .o_data_valid        (o_data_valid),
      .o_data_sof          (o_data_sof),
      .o_frame_good        (o_frame_good),
      .o_frame_bad         (o_frame_bad),
      .o_otn_tx_ack        (o_otn_tx_ack),
      .o_rx_state          (o_rx_state)
   );

   always #5 clk = ~clk;

   initial begin
      forever begin
         @(posedge clk);
         #1;
         tick = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
   end

   always @(posedge clk) if (tick) tick_ctr <= tick_ctr + 1;

   always @(negedge clk) begin
      if (o_data_valid === 1'b1) begin
         got_q.push_back(o_data);
         sof_q.push_back(o_data_sof);
      end
      if (o_frame_good === 1'b1) begin good_cnt++; good_tick = tick_ctr; end
      if (o_frame_bad === 1'b1) begin bad_cnt++; bad_tick = tick_ctr; end
      if (o_data_valid === 1'b1 && (o_frame_good === 1'b1 || o_frame_bad === 1'b1)) overlap_cnt++;
      if (o_otn_tx_ack !== prev_ack) begin
         ack_edge_t.push_back(tick_ctr);
         ack_edge_v.push_back(o_otn_tx_ack);
         prev_ack = o_otn_tx_ack;
      end
   end

   initial begin
      #900000;
      $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
      $fatal(1, "watchdog");
   end

   task automatic clear_mon();
      got_q.delete();
      sof_q.delete();
      good_cnt = 0;
      bad_cnt = 0;
      overlap_cnt = 0;
      ack_edge_t.delete();
      ack_edge_v.delete();
   endtask

   task automatic send_bit(input logic b, input int period);
      int n;
      rx = b;
      n = 0;
      while (n < period) begin
         @(posedge clk);
         if (tick) n++;
      end
      #1;
   endtask

   task automatic send_byte(input logic [7:0] b, input int period);
      for (int k = 0; k < 8; k++) send_bit(b[k], period);
   endtask

   task automatic send_idle(input int nbits);
      for (int k = 0; k < nbits; k++) send_bit(1'b1, BD);
   endtask

   task automatic send_frame(input int period);
      for (int i = 0; i < FB; i++) send_byte(frame[i], period);
   endtask

   function automatic int max_run();
      int   best = 0;
      int   run = 0;
      logic last = 1'b1;
      for (int i = 0; i < FB; i++) begin
         for (int k = 0; k < 8; k++) begin
            if (frame[i][k] == last) run++;
            else run = 1;
            last = frame[i][k];
            if (run > best) best = run;
         end
      end
      return best;
   endfunction

   // mode 0: payload byte n = n mod 256; 1: random; 2: random with short bit runs
   task automatic make_frame(input int mode, input bit corrupt);
      logic [7:0] v, x;
      for (int t = 0; t < 2000; t++) begin
         x = 8'h00;
         for (int i = 0; i < 6; i++) frame[i] = FAS_TB[47-8*i -: 8];
         for (int i = 6; i < FB - 1; i++) begin
            if (mode == 0) v = 8'(i % 256);
            else v = 8'($urandom);
            if (mode == 2) begin
               v[0] = ~frame[i-1][7];
               v[4] = ~v[3];
            end
            frame[i] = v;
            x = x ^ v;
         end
         frame[FB-1] = corrupt ? ~x : x;
         if (mode != 2 || max_run() <= 5) break;
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (o_rx_state !== 3'd0) begin errors++; $display("FAIL reset_state: got %0d want 0", o_rx_state); end
      checks++;
      if (o_otn_tx_ack !== 1'b1) begin errors++; $display("FAIL reset_ack: got %b want 1", o_otn_tx_ack); end
      checks++;
      if (o_data !== 8'h00 || o_data_valid !== 1'b0 || o_data_sof !== 1'b0) begin
         errors++; $display("FAIL reset_data: data %h valid %b sof %b want 00 0 0", o_data, o_data_valid, o_data_sof);
      end
      checks++;
      if (o_frame_good !== 1'b0 || o_frame_bad !== 1'b0) begin
         errors++; $display("FAIL reset_verdict: good %b bad %b want 0 0", o_frame_good, o_frame_bad);
      end
      rst_n = 1'b1;
      send_idle(4);
   endtask

   task automatic test_frame(input string name, input int mode, input bit corrupt,
                             input bit arq, input int period, input bit gaps);
      logic [7:0] x;
      bit         exp_good;
      int         nerr, first_bad, nsof, exp_n;
      longint     ref_t, exp_gap;
      logic       exp_v;
      arq_en = arq;
      make_frame(mode, corrupt);
      x = 8'h00;
      for (int i = 6; i < FB - 1; i++) x = x ^ frame[i];
      exp_good = (x == frame[FB-1]);
      clear_mon();
      gap_mode = gaps;
      send_idle(2);
      send_frame(period);
      send_idle(10);
      gap_mode = 1'b0;

      checks++;
      if (got_q.size() != NPAY) begin
         errors++; $display("FAIL %s strobes: got %0d want %0d", name, got_q.size(), NPAY);
      end
      nerr = 0;
      first_bad = -1;
      for (int i = 0; i < NPAY; i++) begin
         if (i >= got_q.size() || got_q[i] !== frame[6+i]) begin
            nerr++;
            if (first_bad < 0) first_bad = i;
         end
      end
      checks++;
      if (nerr != 0) begin
         errors++;
         $display("FAIL %s payload: %0d wrong bytes, first at %0d got %h want %h", name, nerr, first_bad,
                  (first_bad < got_q.size()) ? got_q[first_bad] : 8'hxx, frame[6+first_bad]);
      end
      nsof = 0;
      foreach (sof_q[i]) if (sof_q[i]) nsof++;
      checks++;
      if (sof_q.size() == 0 || sof_q[0] !== 1'b1 || nsof != 1) begin
         errors++; $display("FAIL %s sof: %0d sof strobes, want exactly one on first byte", name, nsof);
      end
      checks++;
      if (good_cnt != (exp_good ? 1 : 0) || bad_cnt != (exp_good ? 0 : 1)) begin
         errors++; $display("FAIL %s verdict: good %0d bad %0d want good %0d bad %0d", name, good_cnt, bad_cnt,
                            exp_good ? 1 : 0, exp_good ? 0 : 1);
      end
      checks++;
      if (overlap_cnt != 0) begin
         errors++; $display("FAIL %s overlap: valid coincided with verdict %0d times want 0", name, overlap_cnt);
      end
      if (arq) begin
         exp_n = exp_good ? 4 : 2;
         checks++;
         if (ack_edge_v.size() != exp_n) begin
            errors++; $display("FAIL %s ack_edges: got %0d want %0d", name, ack_edge_v.size(), exp_n);
         end else begin
            ref_t = exp_good ? good_tick : bad_tick;
            nerr = 0;
            for (int i = 0; i < exp_n; i++) begin
               exp_v = (i % 2 == 0) ? 1'b0 : 1'b1;
               exp_gap = (i == 0) ? longint'(AG * BD) : (exp_good ? longint'(BD) : longint'(3 * BD));
               if (ack_edge_v[i] !== exp_v || ack_edge_t[i] - ref_t != exp_gap) begin
                  nerr++;
                  $display("FAIL %s ack_edge%0d: level %b after %0d ticks want %b after %0d", name, i,
                           ack_edge_v[i], ack_edge_t[i] - ref_t, exp_v, exp_gap);
               end
               ref_t = ack_edge_t[i];
            end
            checks++;
            if (nerr != 0) errors++;
         end
      end else begin
         checks++;
         if (ack_edge_v.size() != 0) begin
            errors++; $display("FAIL %s ack_idle: %0d ack edges want 0", name, ack_edge_v.size());
         end
      end
      checks++;
      if (o_rx_state !== 3'd0 || o_otn_tx_ack !== 1'b1) begin
         errors++; $display("FAIL %s end_state: state %0d ack %b want 0 1", name, o_rx_state, o_otn_tx_ack);
      end
   endtask

   task automatic test_hunt_noise();
      logic [7:0] pre [4];
      int         nerr;
      pre[0] = 8'hF6; pre[1] = 8'hF6; pre[2] = 8'hF6; pre[3] = 8'h28;
      arq_en = 1'b0;
      make_frame(1, 1'b0);
      clear_mon();
      for (int i = 0; i < 200; i++) send_bit(1'($urandom_range(0, 1)), BD);
      for (int i = 0; i < 4; i++) send_byte(pre[i], BD);
      checks++;
      if (o_rx_state !== 3'd0) begin
         errors++; $display("FAIL hunt_noise early_lock: state %0d want 0", o_rx_state);
      end
      send_frame(BD);
      send_idle(4);
      nerr = 0;
      for (int i = 0; i < NPAY; i++) if (i >= got_q.size() || got_q[i] !== frame[6+i]) nerr++;
      checks++;
      if (got_q.size() != NPAY || nerr != 0) begin
         errors++; $display("FAIL hunt_noise payload: %0d bytes %0d wrong want %0d bytes 0 wrong", got_q.size(), nerr, NPAY);
      end
      checks++;
      if (good_cnt != 1 || bad_cnt != 0) begin
         errors++; $display("FAIL hunt_noise verdict: good %0d bad %0d want 1 0", good_cnt, bad_cnt);
      end
   endtask

   task automatic test_reset_mid_frame();
      arq_en = 1'b1;
      make_frame(0, 1'b0);
      clear_mon();
      fork
         begin
            send_idle(2);
            send_frame(BD);
            send_idle(10);
         end
         begin
            int n = 0;
            while (got_q.size() < 4 && n < FB * 8 * BD * 2) begin
               @(posedge clk);
               n++;
            end
            checks++;
            if (got_q.size() < 4) begin
               errors++; $display("FAIL rst_frame wait: got %0d bytes want 4 before timeout", got_q.size());
            end
            #3 rst_n = 1'b0;
            #1;
            checks++;
            if (o_rx_state !== 3'd0 || o_otn_tx_ack !== 1'b1 || o_data_valid !== 1'b0 || o_data !== 8'h00) begin
               errors++;
               $display("FAIL rst_frame async: state %0d ack %b valid %b data %h want 0 1 0 00",
                        o_rx_state, o_otn_tx_ack, o_data_valid, o_data);
            end
            repeat (3) @(posedge clk);
            #1 rst_n = 1'b1;
         end
      join
      checks++;
      if (got_q.size() != 4 || good_cnt != 0 || bad_cnt != 0) begin
         errors++;
         $display("FAIL rst_frame aftermath: bytes %0d good %0d bad %0d want 4 0 0", got_q.size(), good_cnt, bad_cnt);
      end
   endtask

   task automatic test_reset_mid_ack();
      int n;
      arq_en = 1'b1;
      make_frame(0, 1'b0);
      clear_mon();
      send_idle(2);
      send_frame(BD);
      n = 0;
      while (o_otn_tx_ack !== 1'b0 && n < (AG + 2) * BD * 2) begin
         @(posedge clk);
         #1;
         n++;
      end
      checks++;
      if (o_otn_tx_ack !== 1'b0) begin
         errors++; $display("FAIL rst_ack start: ack %b want 0 within bound", o_otn_tx_ack);
      end
      repeat (5) @(posedge clk);
      #3 rst_n = 1'b0;
      #1;
      checks++;
      if (o_otn_tx_ack !== 1'b1 || o_rx_state !== 3'd0) begin
         errors++; $display("FAIL rst_ack async: ack %b state %0d want 1 0", o_otn_tx_ack, o_rx_state);
      end
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      send_idle(10);
      checks++;
      if (o_otn_tx_ack !== 1'b1 || ack_edge_v.size() != 2) begin
         errors++; $display("FAIL rst_ack after: ack %b edges %0d want 1 2", o_otn_tx_ack, ack_edge_v.size());
      end
   endtask

   initial begin
      test_reset();
      test_frame("clean_arq", 0, 1'b0, 1'b1, BD, 1'b0);
      test_frame("bad_checksum", 0, 1'b1, 1'b1, BD, 1'b0);
      test_frame("no_arq", 1, 1'b0, 1'b0, BD, 1'b0);
      test_frame("tick_gaps", 1, 1'b0, 1'b1, BD, 1'b1);
      test_frame("drift19", 2, 1'b0, 1'b0, 19, 1'b0);
      test_frame("drift21", 2, 1'b0, 1'b1, 21, 1'b0);
      test_hunt_noise();
      test_reset_mid_frame();
      test_frame("after_reset", 0, 1'b0, 1'b1, BD, 1'b0);
      test_reset_mid_ack();
      test_frame("back_to_back", 1, 1'b1, 1'b0, BD, 1'b0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/otn_frame_rx.md
OTN_FRAME_RX -- requirements
Module: otn_frame_rx

Interface
REQ-001 Parameter FRAME_BYTES, default 4164: total bytes per frame, FAS included.
REQ-002 Parameter BAUD_DIV, default 20: i_sclk_en_16_x_baud pulses per bit period.
REQ-003 Parameter SAMPLE_PHASE, default 9: phase count at which a bit is sampled.
REQ-004 Parameter ACK_GAP, default 4: idle bit periods between frame end and ACK start bit.
REQ-005 Parameter FAS, default 48'hF6F6F6282828: frame alignment pattern; byte 0 is the first byte on the line.
REQ-006 The block SHALL have one clock; reset is asynchronous and active-low.
REQ-007 i_clk  input  1  system clock.
REQ-008 i_rst_n  input  1  asynchronous active-low reset.
REQ-009 i_sclk_en_16_x_baud  input  1  clock-enable tick.
REQ-010 i_otn_rx_data  input  1  asynchronous serial frame stream, NRZ, LSB-first, no start/stop bits.
REQ-011 i_arq_en  input  1  when high, an ACK is returned after every frame.
REQ-012 o_data  output  8  received payload byte.
REQ-013 o_data_valid  output  1  one-cycle strobe qualifying o_data.
REQ-014 o_data_sof  output  1  high with o_data_valid on the first payload byte (byte 6).
REQ-015 o_frame_good / o_frame_bad  output  1 each  one-cycle verdict pulses.
REQ-016 o_otn_tx_ack  output  1  serial ACK line, idle high.
REQ-017 o_rx_state  output  3  current state encoding.

Function
REQ-018 i_otn_rx_data SHALL pass through a 2-flop synchronizer before any use.
REQ-019 Bit timing: a phase counter (0..BAUD_DIV-1) SHALL advance on each tick, SHALL clear to 0 on any synchronized input transition, and SHALL wrap at BAUD_DIV-1; a bit is sampled when phase == SAMPLE_PHASE and a tick is present.
REQ-020 States SHALL be HUNT=0, RECV=1, CHECK=2, GAP=3, ACK=4.
REQ-021 HUNT: a 48-bit shift register SHALL take each sampled bit; a match to FAS, with bit order per REQ-010, SHALL enter RECV with byte count = 6.
REQ-022 RECV: bits SHALL be assembled LSB-first; each completed byte SHALL increment the byte count.
REQ-023 Bytes 6..FRAME_BYTES-2 SHALL appear on o_data with o_data_valid one clock after their last bit is sampled, and SHALL be XOR-accumulated into an 8-bit checksum.
REQ-024 Byte FRAME_BYTES-1 is the checksum; it SHALL NOT be output, and its completion SHALL enter CHECK.
REQ-025 CHECK lasts one clock: match → o_frame_good pulse; mismatch → o_frame_bad pulse; verdict latched.
REQ-026 From CHECK: if i_arq_en is high, go to GAP; otherwise go to HUNT with the FAS register cleared.
REQ-027 GAP: after ACK_GAP bit periods, counted by a free-running divider of BAUD_DIV ticks, go to ACK.
REQ-028 ACK: o_otn_tx_ack SHALL drive 0 (start), then the verdict (1=good), then 0 (stop), each for BAUD_DIV ticks; it returns to 1, and the state returns to HUNT.
REQ-029 Sampled input in GAP/ACK SHALL be ignored; no partial-frame recovery exists.
REQ-030 o_data_valid and a verdict pulse SHALL never coincide.
REQ-031 A tick absent for long periods SHALL only stall timing, never corrupt state.

Reset
REQ-032 Reset SHALL force: state HUNT, all counters 0, shift/checksum registers 0, o_data 0, all strobes 0, o_otn_tx_ack 1.
REQ-033 Reset mid-RECV or mid-ACK SHALL abort immediately; the line returns high within the same asynchronous assertion.

Structure
REQ-034 State encodings, FAS, FRAME_BYTES and BAUD_DIV defaults SHALL live in a shared package, otn_pkg.
REQ-035 The bit-timing recovery (synchronizer, edge detect, phase counter, sample strobe) SHALL be one sub-module, otn_bit_sampler.

Verification
REQ-036 Clean frame, payload bytes n mod 256 with the correct checksum, i_arq_en=1 → 4157 valid strobes, sof on the first, one o_frame_good, ACK line 1→0,1,0→1 with 20 ticks per bit.
REQ-037 Same frame with the checksum byte flipped → o_frame_bad; ACK bit 0.
REQ-038 i_arq_en=0 → verdict pulse; o_otn_tx_ack stays 1; state back to HUNT.
REQ-039 200 random bits then FAS, with pattern 0xF6F6F628 preloaded as noise → lock only on the true FAS.
REQ-040 Input bit period 19 or 21 ticks over a full frame → all bytes correct (edge re-alignment).
REQ-041 Reset asserted at byte 2000 → outputs at reset values asynchronously; the next clean frame is received correctly.
